// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
// Accepts a/b on start while idle and produces a 2*WIDTH-bit product as hi/lo.
// hi/lo hold the previous product until the next completion, so a downstream
// select mux can keep reading it while a new multiply is running.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // The accumulator and multiplicand carry one extra bit so that A - M
    // cannot overflow when a is the most-negative value.
    logic signed [WIDTH:0] m;
    logic signed [WIDTH:0] acc;
    logic [WIDTH-1:0]      q;
    logic                  q_1;
    logic [CNT_W-1:0]      count;

    logic                  accept;
    logic                  last_step;
    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] acc_shift;
    logic [WIDTH-1:0]      q_shift;

    // Booth recoding of the current multiplier bit pair {Q[0], Q_-1}.
    function automatic logic signed [WIDTH:0] booth_add(
        input logic signed [WIDTH:0] acc_in,
        input logic signed [WIDTH:0] m_in,
        input logic [1:0]            pair
    );
        case (pair)
            2'b01:   return acc_in + m_in;
            2'b10:   return acc_in - m_in;
            default: return acc_in;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and step qualifiers.
    always_comb begin
        busy      = (state == RUN);
        accept    = (state == IDLE) && start;
        last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    end

    // One Booth step: conditional add/subtract, then arithmetic right shift of {A,Q,Q_-1}.
    always_comb begin
        sum       = booth_add(acc, m, {q[0], q_1});
        acc_shift = {sum[WIDTH], sum[WIDTH:1]};
        q_shift   = {sum[0], q[WIDTH-1:1]};
    end

    // Datapath registers: load on accept, step while running, publish on the last step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                m     <= {a[WIDTH-1], a};
                acc   <= '0;
                q     <= b;
                q_1   <= 1'b0;
                count <= '0;
            end else if (state == RUN) begin
                acc   <= acc_shift;
                q     <= q_shift;
                q_1   <= q[0];
                count <= count + CNT_W'(1);
                if (last_step) begin
                    hi   <= acc_shift[WIDTH-1:0];
                    lo   <= q_shift;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed scenarios plus randomized
// operands, compared against a plain signed-multiply reference.
module tb_booth_mult_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    // Product the bench expects hi/lo to be holding right now.
    logic [2*W-1:0] held_prod = '0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product at full 2W width.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        sx = $signed({{W{x[W-1]}}, x});
        sy = $signed({{W{y[W-1]}}, y});
        return sx * sy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one multiply from idle, scramble operands while it runs, and check
    // latency, hold behaviour during RUN and the final product.
    task automatic run_mult(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] exp;
        int n;
        int hold_bad;
        exp = ref_mul(x, y);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        hold_bad = 0;
        while (n < 100) begin
            a = $urandom;
            b = $urandom;
            if ({hi, lo} !== held_prod || busy !== 1'b1) hold_bad++;
            tick();
            n++;
            if (done) break;
        end
        check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        check({tag, "_lat"}, 64'(n), 64'd32);
        check({tag, "_prod"}, {hi, lo}, exp);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        held_prod = exp;
    endtask

    initial begin
        int n;
        int dones;
        int bad;
        int pos [$];

        start = 1'b0;
        a = '0;
        b = '0;
        reset = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Test 1: 3 * 5
        run_mult("t1", 32'd3, 32'd5);
        check("t1_const", {hi, lo}, 64'h00000000_0000000F);

        // Test 6: long idle keeps result and stays quiet
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'h0000000F) bad++;
        end
        check("t6_idle_hold", 64'(bad), 64'd0);

        // Test 2: signed corners
        run_mult("t2a", 32'hFFFFFFF9, 32'd6);
        check("t2a_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        run_mult("t2b", 32'h80000000, 32'h80000000);
        check("t2b_const", {hi, lo}, 64'h40000000_00000000);
        run_mult("t2c", 32'h80000000, 32'd1);
        check("t2c_const", {hi, lo}, 64'hFFFFFFFF_80000000);
        run_mult("t2d", 32'h7FFFFFFF, 32'h80000000);
        run_mult("t2e", 32'h0, 32'h80000000);

        // Test 3: start while busy is ignored
        tick();
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        n = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i >= 10 && i <= 25) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                if (n == 0) n = i;
                check("t3_prod", {hi, lo}, 64'd6);
            end
        end
        check("t3_dones", 64'(dones), 64'd1);
        check("t3_lat", 64'(n), 64'd32);
        check("t3_idle", 64'(busy), 64'd0);
        held_prod = 64'd6;

        // Test 4: reset mid-operation
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b0;
        #1;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_hilo", {hi, lo}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        held_prod = '0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("t4_no_done", 64'(bad), 64'd0);
        run_mult("t4b", 32'd4, 32'd4);
        check("t4b_const", {hi, lo}, 64'h10);

        // Test 5: start held high -> back-to-back multiplies
        tick();
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        bad = 0;
        n = 0;
        while (n < 200 && pos.size() < 3) begin
            tick();
            n++;
            if (busy === done) bad++;
            if (done) begin
                pos.push_back(n);
                check("t5_prod", {hi, lo}, 64'd1);
            end
        end
        start = 1'b0;
        check("t5_count", 64'(pos.size()), 64'd3);
        check("t5_busy_pattern", 64'(bad), 64'd0);
        if (pos.size() == 3) begin
            check("t5_first", 64'(pos[0]), 64'd32);
            check("t5_gap1", 64'(pos[1] - pos[0]), 64'd33);
            check("t5_gap2", 64'(pos[2] - pos[1]), 64'd33);
        end
        tick();
        check("t5_stop", 64'(busy), 64'd0);
        held_prod = 64'd1;

        // Randomized operands
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = $urandom;
            if (i % 5 == 1) x = 32'h80000000;
            if (i % 7 == 2) y = 32'hFFFFFFFF;
            tick();
            run_mult("rnd", x, y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
